// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared types and helpers
// for the shift-sequence counter.
package shift_seq_pkg;

  typedef enum logic {
    MODE_JOHNSON = 1'b0,
    MODE_RING    = 1'b1
  } ctr_mode_e;

  function automatic logic [31:0] seed(
    input ctr_mode_e mode,
    input int        width
  );
    logic [31:0] s;
    logic [31:0] m;
    s = (mode == MODE_RING) ? 32'd1 : 32'd0;
    m = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return s & m;
  endfunction

endpackage

// File: rtl/shift_seq_decode.sv
// shift_seq_decode: legality check and
// phase index of the current counter code.
module shift_seq_decode
  import shift_seq_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int IDX_W = $clog2(2*WIDTH)
) (
  input  logic [WIDTH-1:0] out,
  input  ctr_mode_e        mode_q,
  output logic             legal,
  output logic [IDX_W-1:0] idx
);

  int k;
  int p;
  int t;
  int v;

  // popcount, hot position, edge count -> legal/idx
  always_comb begin
    k = 0;
    p = 0;
    t = 0;
    v = 0;
    legal = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      k = k + int'(out[i]);
      if (out[i]) p = i;
    end
    for (int i = 1; i < WIDTH; i++) begin
      t = t + int'(out[i] ^ out[i-1]);
    end
    if (mode_q == MODE_RING) begin
      legal = (k == 1);
      v = (WIDTH - p) % WIDTH;
    end else begin
      legal = (t <= 1);
      v = out[WIDTH-1] ? k
        : (2*WIDTH - k) % (2*WIDTH);
    end
    idx = legal ? IDX_W'(v) : '0;
  end

endmodule

// File: rtl/shift_seq_ctr.sv
// shift_seq_ctr: Johnson/ring phase generator
// with load, reseed, self-correction and wrap.
module shift_seq_ctr
  import shift_seq_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int IDX_W = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic [IDX_W-1:0] idx,
  output logic             wrap,
  output logic             illegal
);

  ctr_mode_e        mode_in;
  ctr_mode_e        mode_q;
  ctr_mode_e        mode_d;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] step_v;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] seed_cur;
  logic             wrap_q;
  logic             wrap_d;
  logic             legal;

  assign mode_in  = ctr_mode_e'(mode);
  assign seed_in  = WIDTH'(seed(mode_in, WIDTH));
  assign seed_cur = WIDTH'(seed(mode_q, WIDTH));

  shift_seq_decode #(
    .WIDTH (WIDTH)
  ) u_dec (
    .out    (out_q),
    .mode_q (mode_q),
    .legal  (legal),
    .idx    (idx)
  );

  assign out     = out_q;
  assign wrap    = wrap_q;
  assign illegal = ~legal;

  // one-step shift for active mode and direction
  always_comb begin
    step_v = out_q;
    unique case ({mode_q == MODE_RING, dir})
      2'b00: step_v = {~out_q[0], out_q[WIDTH-1:1]};
      2'b01: step_v = {out_q[WIDTH-2:0], ~out_q[WIDTH-1]};
      2'b10: step_v = {out_q[0], out_q[WIDTH-1:1]};
      2'b11: step_v = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
    endcase
  end

  // priority: load, reseed, correct, step, hold
  always_comb begin
    out_d  = out_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
    if (load) begin
      out_d = load_val;
    end else if (mode_in != mode_q) begin
      out_d  = seed_in;
      mode_d = mode_in;
    end else if (en && !legal) begin
      out_d = seed_cur;
    end else if (en) begin
      out_d  = step_v;
      wrap_d = (step_v == seed_cur);
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q  <= '0;
      mode_q <= MODE_JOHNSON;
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      mode_q <= mode_d;
      wrap_q <= wrap_d;
    end
  end

endmodule

// File: tb/tb_shift_seq_ctr.sv
// tb_shift_seq_ctr: directed checks of the
// shift-sequence counter at WIDTH=4.
module tb_shift_seq_ctr;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'b0;
  logic [3:0] out;
  logic [2:0] idx;
  logic       wrap;
  logic       illegal;
  logic [8:0] got;
  logic [8:0] exp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign got = {out, idx, wrap, illegal};

  shift_seq_ctr #(.WIDTH(4)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .out      (out),
    .idx      (idx),
    .wrap     (wrap),
    .illegal  (illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic m);
    mode = m;
    en   = 1'b0;
    load = 1'b0;
    dir  = 1'b0;
    @(posedge clk);
    #2 rstn = 1'b0;
    #2 rstn = 1'b1;
  endtask

  task automatic test_reset();
    mode = 1'b0;
    rstn = 1'b0;
    #3;
    exp = {4'b0000, 3'd0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset got=%b exp=%b", got, exp);
    end
    @(posedge clk);
    #2 rstn = 1'b1;
  endtask

  task automatic test_johnson();
    logic [3:0] eo [8] = '{4'b1000, 4'b1100,
      4'b1110, 4'b1111, 4'b0111, 4'b0011,
      4'b0001, 4'b0000};
    do_reset(1'b0);
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = {eo[i], 3'((i + 1) % 8),
             (i == 7), 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL johnson[%0d] got=%b exp=%b",
                 i, got, exp);
      end
    end
  endtask

  task automatic test_dir_reverse();
    logic [8:0] e [3] = '{
      {4'b1100, 3'd2, 1'b0, 1'b0},
      {4'b1000, 3'd1, 1'b0, 1'b0},
      {4'b0000, 3'd0, 1'b1, 1'b0}};
    tick();
    tick();
    tick();
    exp = {4'b1110, 3'd3, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL rev_start got=%b exp=%b",
               got, exp);
    end
    dir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (got !== e[i]) begin
        errors++;
        $display("FAIL reverse[%0d] got=%b exp=%b",
                 i, got, e[i]);
      end
    end
    dir = 1'b0;
  endtask

  task automatic test_load_illegal();
    load     = 1'b1;
    load_val = 4'b0101;
    tick();
    load = 1'b0;
    exp  = {4'b0101, 3'd0, 1'b0, 1'b1};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL load_ill got=%b exp=%b",
               got, exp);
    end
    tick();
    exp = {4'b0000, 3'd0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL correct got=%b exp=%b",
               got, exp);
    end
  endtask

  task automatic test_mode_toggle();
    logic [8:0] e [5] = '{
      {4'b0001, 3'd0, 1'b0, 1'b0},
      {4'b1000, 3'd1, 1'b0, 1'b0},
      {4'b0100, 3'd2, 1'b0, 1'b0},
      {4'b0010, 3'd3, 1'b0, 1'b0},
      {4'b0001, 3'd0, 1'b1, 1'b0}};
    load     = 1'b1;
    load_val = 4'b1110;
    tick();
    load = 1'b0;
    exp  = {4'b1110, 3'd3, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL load_legal got=%b exp=%b",
               got, exp);
    end
    mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (got !== e[i]) begin
        errors++;
        $display("FAIL toggle[%0d] got=%b exp=%b",
                 i, got, e[i]);
      end
    end
  endtask

  task automatic test_ring_misc();
    dir = 1'b1;
    tick();
    exp = {4'b0010, 3'd3, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL ring_left got=%b exp=%b",
               got, exp);
    end
    dir      = 1'b0;
    load     = 1'b1;
    load_val = 4'b0011;
    tick();
    load = 1'b0;
    exp  = {4'b0011, 3'd0, 1'b0, 1'b1};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL ring_ill got=%b exp=%b",
               got, exp);
    end
    en = 1'b0;
    tick();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL hold_ill got=%b exp=%b",
               got, exp);
    end
    en = 1'b1;
    tick();
    exp = {4'b0001, 3'd0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL ring_fix got=%b exp=%b",
               got, exp);
    end
  endtask

  task automatic test_reset_ring();
    logic [8:0] e [5] = '{
      {4'b0001, 3'd0, 1'b0, 1'b0},
      {4'b1000, 3'd1, 1'b0, 1'b0},
      {4'b0100, 3'd2, 1'b0, 1'b0},
      {4'b0010, 3'd3, 1'b0, 1'b0},
      {4'b0001, 3'd0, 1'b1, 1'b0}};
    do_reset(1'b1);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (got !== e[i]) begin
        errors++;
        $display("FAIL rst_ring[%0d] got=%b exp=%b",
                 i, got, e[i]);
      end
    end
    en = 1'b0;
    tick();
    exp = {4'b0001, 3'd0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL hold got=%b exp=%b", got, exp);
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    exp = {4'b0111, 3'd5, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL pre_arst got=%b exp=%b",
               got, exp);
    end
    #1 rstn = 1'b0;
    #1;
    exp = {4'b0000, 3'd0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL arst got=%b exp=%b", got, exp);
    end
    #2 rstn = 1'b1;
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_johnson();
    test_dir_reverse();
    test_load_illegal();
    test_mode_toggle();
    test_ring_misc();
    test_reset_ring();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
